// File: rtl/ibex_wb_pkg.sv
// ============================================================================
// Module   : ibex_wb_pkg
// Brief    : Shared types and helpers for the ID-stage writeback arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ibex_wb_pkg;

    localparam int unsigned WbDataW = 32;
    localparam int unsigned WbAddrW = 5;

    localparam logic [WbAddrW-1:0] RegZero = 5'd0;

    typedef struct packed {
        logic [WbAddrW-1:0] waddr;
        logic [WbDataW-1:0] wdata;
    } wb_req_t;

    typedef enum logic [0:0] {
        LD_IDLE    = 1'b0,
        LD_PENDING = 1'b1
    } ld_sb_state_e;

    // True when a live (non-x0) destination collides with any operand the ID
    // instruction actually uses, covering both RAW and WAW.
    function automatic logic reg_hit(
        input logic [WbAddrW-1:0] addr,
        input logic [WbAddrW-1:0] raddr_a,
        input logic               ra_used,
        input logic [WbAddrW-1:0] raddr_b,
        input logic               rb_used,
        input logic [WbAddrW-1:0] waddr,
        input logic               we
    );
        return (addr != RegZero) &&
               ((ra_used && (addr == raddr_a)) ||
                (rb_used && (addr == raddr_b)) ||
                (we      && (addr == waddr)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/ibex_wb_arbiter_if.sv
// ============================================================================
// Module   : ibex_wb_arbiter_if
// Brief    : EX/LSU/ID-facing bus of the writeback arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ibex_wb_arbiter_if
    import ibex_wb_pkg::*;
#(
    parameter int unsigned DataW = WbDataW,
    parameter int unsigned AddrW = WbAddrW
);
    logic             ex_we_i;
    logic [AddrW-1:0] ex_waddr_i;
    logic [DataW-1:0] ex_wdata_i;
    logic             ex_ready_o;
    logic             ld_issue_i;
    logic [AddrW-1:0] ld_waddr_i;
    logic             lsu_valid_i;
    logic             lsu_err_i;
    logic [DataW-1:0] lsu_wdata_i;
    logic [AddrW-1:0] id_raddr_a_i;
    logic [AddrW-1:0] id_raddr_b_i;
    logic             id_ra_used_i;
    logic             id_rb_used_i;
    logic             id_we_i;
    logic [AddrW-1:0] id_waddr_i;
    logic             stall_hz_o;
    logic             ld_pending_o;
    logic             rf_we_o;
    logic [AddrW-1:0] rf_waddr_o;
    logic [DataW-1:0] rf_wdata_o;

    modport slave (
        input  ex_we_i, ex_waddr_i, ex_wdata_i,
        input  ld_issue_i, ld_waddr_i,
        input  lsu_valid_i, lsu_err_i, lsu_wdata_i,
        input  id_raddr_a_i, id_raddr_b_i, id_ra_used_i, id_rb_used_i,
        input  id_we_i, id_waddr_i,
        output ex_ready_o, stall_hz_o, ld_pending_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o
    );

    modport master (
        output ex_we_i, ex_waddr_i, ex_wdata_i,
        output ld_issue_i, ld_waddr_i,
        output lsu_valid_i, lsu_err_i, lsu_wdata_i,
        output id_raddr_a_i, id_raddr_b_i, id_ra_used_i, id_rb_used_i,
        output id_we_i, id_waddr_i,
        input  ex_ready_o, stall_hz_o, ld_pending_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o
    );

endinterface

`default_nettype wire

// File: rtl/ibex_wb_fifo.sv
// ============================================================================
// Module   : ibex_wb_fifo
// Brief    : Small FIFO of deferred EX writebacks with per-entry visibility.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_wb_fifo
    import ibex_wb_pkg::*;
#(
    parameter int unsigned WbBufDepth = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  push_i,
    input  wb_req_t                               push_data_i,
    input  logic                                  pop_i,
    output wb_req_t                               head_o,
    output logic                                  full_o,
    output logic                                  empty_o,
    output logic [WbBufDepth-1:0]                 entry_valid_o,
    output logic [WbBufDepth-1:0][WbAddrW-1:0]    entry_addr_o
);

    localparam int unsigned c_ptr_w = $clog2(WbBufDepth);
    localparam int unsigned c_cnt_w = c_ptr_w + 1;

    wb_req_t              r_mem [WbBufDepth];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign full_o    = (r_count == c_cnt_w'(WbBufDepth));
    assign empty_o   = (r_count == '0);
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;
    assign head_o    = r_mem[r_rd_ptr];

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data_i;
    end

    for (genvar g = 0; g < WbBufDepth; g++) begin : g_entry
        logic [c_ptr_w-1:0] w_off;
        assign w_off            = c_ptr_w'(g) - r_rd_ptr;
        assign entry_valid_o[g] = ({1'b0, w_off} < r_count);
        assign entry_addr_o[g]  = r_mem[g].waddr;
    end

endmodule

`default_nettype wire

// File: rtl/ibex_wb_arbiter.sv
// ============================================================================
// Module   : ibex_wb_arbiter
// Brief    : Register-file write-port arbiter (LSU > buffered EX > EX bypass)
//            with single-load scoreboard and load-use / WAW stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_wb_arbiter
    import ibex_wb_pkg::*;
#(
    parameter int unsigned DataW      = WbDataW,
    parameter int unsigned AddrW      = WbAddrW,
    parameter int unsigned WbBufDepth = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    ibex_wb_arbiter_if.slave  bus
);

    ld_sb_state_e                       r_state;
    ld_sb_state_e                       w_state_nxt;
    logic [AddrW-1:0]                   r_ld_addr;
    logic [AddrW-1:0]                   w_ld_addr_nxt;

    logic                               w_retire;
    logic                               w_lsu_wr;
    logic                               w_ex_acc;
    logic                               w_bypass;
    logic                               w_push;
    logic                               w_pop;
    logic                               w_fifo_full;
    logic                               w_fifo_empty;
    wb_req_t                            w_fifo_head;
    wb_req_t                            w_ex_req;
    logic [WbBufDepth-1:0]              w_entry_valid;
    logic [WbBufDepth-1:0][WbAddrW-1:0] w_entry_addr;

    logic                               w_rf_we;
    logic [AddrW-1:0]                   w_rf_waddr;
    logic [DataW-1:0]                   w_rf_wdata;
    logic                               w_stall;

    // ---------------- load scoreboard ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= LD_IDLE;
            r_ld_addr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ld_addr <= w_ld_addr_nxt;
        end
    end

    // An issue while a load is still outstanding is dropped unless the old
    // load retires in the same cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_ld_addr_nxt = r_ld_addr;
        unique case (r_state)
            LD_IDLE: begin
                if (bus.ld_issue_i) begin
                    w_state_nxt   = LD_PENDING;
                    w_ld_addr_nxt = bus.ld_waddr_i;
                end
            end
            LD_PENDING: begin
                if (bus.lsu_valid_i) begin
                    if (bus.ld_issue_i) begin
                        w_ld_addr_nxt = bus.ld_waddr_i;
                    end else begin
                        w_state_nxt = LD_IDLE;
                    end
                end
            end
            default: w_state_nxt = LD_IDLE;
        endcase
    end

    // ---------------- write-port arbitration ----------------
    assign w_retire = (r_state == LD_PENDING) && bus.lsu_valid_i;
    assign w_lsu_wr = w_retire && !bus.lsu_err_i && (r_ld_addr != RegZero);
    assign w_ex_acc = bus.ex_we_i && !w_fifo_full && (bus.ex_waddr_i != RegZero);
    assign w_bypass = w_ex_acc && !w_lsu_wr && w_fifo_empty;
    assign w_push   = w_ex_acc && !w_bypass;
    assign w_pop    = !w_lsu_wr && !w_fifo_empty;

    assign w_ex_req.waddr = bus.ex_waddr_i;
    assign w_ex_req.wdata = bus.ex_wdata_i;

    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_waddr = '0;
        w_rf_wdata = '0;
        if (w_lsu_wr) begin
            w_rf_we    = 1'b1;
            w_rf_waddr = r_ld_addr;
            w_rf_wdata = bus.lsu_wdata_i;
        end else if (w_pop) begin
            w_rf_we    = 1'b1;
            w_rf_waddr = w_fifo_head.waddr;
            w_rf_wdata = w_fifo_head.wdata;
        end else if (w_bypass) begin
            w_rf_we    = 1'b1;
            w_rf_waddr = bus.ex_waddr_i;
            w_rf_wdata = bus.ex_wdata_i;
        end
    end

    ibex_wb_fifo #(
        .WbBufDepth (WbBufDepth)
    ) u_fifo (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .push_i        (w_push),
        .push_data_i   (w_ex_req),
        .pop_i         (w_pop),
        .head_o        (w_fifo_head),
        .full_o        (w_fifo_full),
        .empty_o       (w_fifo_empty),
        .entry_valid_o (w_entry_valid),
        .entry_addr_o  (w_entry_addr)
    );

    // ---------------- hazard detection ----------------
    // Deliberately independent of ex_we_i to keep the ID controller loop-free.
    always_comb begin
        w_stall = 1'b0;
        if ((r_state == LD_PENDING) && !bus.lsu_valid_i &&
            reg_hit(r_ld_addr, bus.id_raddr_a_i, bus.id_ra_used_i,
                    bus.id_raddr_b_i, bus.id_rb_used_i,
                    bus.id_waddr_i, bus.id_we_i)) begin
            w_stall = 1'b1;
        end
        for (int i = 0; i < int'(WbBufDepth); i++) begin
            if (w_entry_valid[i] &&
                reg_hit(w_entry_addr[i], bus.id_raddr_a_i, bus.id_ra_used_i,
                        bus.id_raddr_b_i, bus.id_rb_used_i,
                        bus.id_waddr_i, bus.id_we_i)) begin
                w_stall = 1'b1;
            end
        end
    end

    assign bus.ex_ready_o   = !w_fifo_full;
    assign bus.ld_pending_o = (r_state == LD_PENDING);
    assign bus.stall_hz_o   = w_stall;
    assign bus.rf_we_o      = w_rf_we;
    assign bus.rf_waddr_o   = w_rf_waddr;
    assign bus.rf_wdata_o   = w_rf_wdata;

endmodule

`default_nettype wire
